fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the asynchronous-read instruction memory. It owns the fetch PC and drives the memory address. It captures the returned instruction into a 2-entry fetch queue tagged with its PC, and presents the queue head to decode over a valid/ready handshake. It also handles branch/jump redirects (queue flush) and halts fetching when a HALT instruction word is fetched.

---
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the async instruction memory,
// buffers fetched words in a 2-entry queue and hands them to decode over valid/ready.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready,
    output logic                  halted,
    output logic [1:0]            q_count
);

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] head_instr, tail_instr;
    logic [ADDR_WIDTH-1:0] head_pc, tail_pc;
    logic                  push, pop;

    // A redirect hides the head so decode can never accept a flushed entry.
    assign out_valid = (count != 2'd0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = (state == S_RUN) && run && !redirect_valid &&
                       ((count != 2'd2) || pop);

    assign imem_addr = fetch_pc;
    assign out_instr = head_instr;
    assign out_pc    = head_pc;
    assign q_count   = count;
    assign halted    = (state == S_HALTED);

    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = S_RUN;
        else if (push && (imem_instr == HALT_INSTR))
            state_nxt = S_HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= redirect_pc;
        else if (push)
            fetch_pc <= fetch_pc + 1'b1;
    end

    // Queue kept as head/tail slots; the head always sits in the head_* registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            head_instr <= '0;
            head_pc    <= '0;
            tail_instr <= '0;
            tail_pc    <= '0;
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= imem_instr;
                        head_pc    <= fetch_pc;
                    end else begin
                        tail_instr <= imem_instr;
                        tail_pc    <= fetch_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_instr <= imem_instr;
                        head_pc    <= fetch_pc;
                    end else begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= imem_instr;
                        tail_pc    <= fetch_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic checked every
// cycle against a queue-based behavioural model of the fetch sequencer.
module tb_fetch_sequencer;

    localparam logic [11:0] HALT = 12'hFFF;

    logic        clk;
    logic        rst;
    logic        run;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_addr;
    logic [11:0] imem_instr;
    logic        out_valid;
    logic [11:0] out_instr;
    logic [7:0]  out_pc;
    logic        out_ready;
    logic        halted;
    logic [1:0]  q_count;

    logic [11:0] mem [256];

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(12),
        .RESET_PC  (8'h00),
        .HALT_INSTR(HALT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready),
        .halted        (halted),
        .q_count       (q_count)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of {instr, pc}, the fetch PC and a halted flag.
    typedef struct {
        logic [11:0] instr;
        logic [7:0]  pc;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] mpc = 8'h00;
    bit         mhalt = 1'b0;
    bit         mstarted = 1'b0;
    bit         m_pop, m_push;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mpc      = 8'h00;
            mhalt    = 1'b0;
            mstarted = 1'b1;
        end else if (mstarted) begin
            if (redirect_valid) begin
                mq.delete();
                mpc   = redirect_pc;
                mhalt = 1'b0;
            end else begin
                m_pop  = (mq.size() != 0) && out_ready;
                m_push = !mhalt && run && ((mq.size() < 2) || m_pop);
                if (m_pop)
                    void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back('{instr: mem[mpc], pc: mpc});
                    if (mem[mpc] == HALT)
                        mhalt = 1'b1;
                    mpc = mpc + 8'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mstarted) begin
            logic exp_valid;
            exp_valid = (mq.size() != 0) && !redirect_valid;
            chk("m_out_valid", out_valid, exp_valid);
            chk("m_q_count", q_count, mq.size());
            chk("m_halted", halted, mhalt);
            chk("m_imem_addr", imem_addr, mpc);
            if (exp_valid) begin
                chk("m_out_instr", out_instr, mq[0].instr);
                chk("m_out_pc", out_pc, mq[0].pc);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         seen;
        bit         saw6;
        logic [7:0] epc;

        rst = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 12'hFFE));
        mem[0] = 12'h101; mem[1] = 12'h102; mem[2] = 12'h103; mem[3] = 12'h104;

        // Reset state
        cyc(); cyc();
        chk("rst_q_count", q_count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);

        // Streaming at one instruction per cycle
        rst = 1'b0; run = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_instr", out_instr, 12'h101 + i);
            chk("t1_pc", out_pc, i);
            chk("t1_count", q_count, 1);
            chk("t1_valid", out_valid, 1);
        end

        // Back-pressure saturates the queue
        rst = 1'b1; out_ready = 1'b0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("t2_count", q_count, 2);
        chk("t2_addr", imem_addr, 2);
        chk("t2_hold_instr", out_instr, 12'h101);
        chk("t2_hold_pc", out_pc, 0);
        out_ready = 1'b1;
        cyc();
        chk("t2_instr1", out_instr, 12'h102);
        cyc();
        chk("t2_instr2", out_instr, 12'h103);

        // Redirect flushes a full queue
        chk("t3_full", q_count, 2);
        mem[8'h40] = 12'h5A5;
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        #1;
        chk("t3_masked", out_valid, 0);
        cyc();
        redirect_valid = 1'b0;
        chk("t3_flush", q_count, 0);
        chk("t3_valid0", out_valid, 0);
        chk("t3_addr", imem_addr, 8'h40);
        cyc();
        chk("t3_valid1", out_valid, 1);
        chk("t3_pc", out_pc, 8'h40);
        chk("t3_instr", out_instr, 12'h5A5);

        // HALT word is delivered and stops fetching
        mem[5] = HALT;
        redirect_valid = 1'b1; redirect_pc = 8'h03;
        cyc();
        redirect_valid = 1'b0;
        seen = 1'b0; saw6 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (out_valid && out_pc == 8'h05 && !seen) begin
                seen = 1'b1;
                chk("t4_halt_instr", out_instr, HALT);
                chk("t4_halt_flag", halted, 1);
            end
            if (out_valid && out_pc == 8'h06) saw6 = 1'b1;
        end
        chk("t4_halt_seen", seen, 1);
        chk("t4_no_pc6", saw6, 0);
        chk("t4_addr_hold", imem_addr, 6);
        chk("t4_drained", out_valid, 0);
        mem[8'h10] = 12'h3C3;
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        cyc();
        redirect_valid = 1'b0;
        chk("t4_unhalt", halted, 0);
        cyc();
        chk("t4_resume_pc", out_pc, 8'h10);
        chk("t4_resume_instr", out_instr, 12'h3C3);

        // PC wraps at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            epc = 8'hFE + 8'(i);
            chk("t5_wrap_pc", out_pc, epc);
            chk("t5_wrap_valid", out_valid, 1);
        end

        // Reset mid-stream, then no fetching with run low
        out_ready = 1'b0;
        cyc(); cyc();
        chk("t6_full", q_count, 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0; run = 1'b0; out_ready = 1'b1;
        chk("t6_count", q_count, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_addr", imem_addr, 0);
        chk("t6_halted", halted, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_idle_addr", imem_addr, 0);
            chk("t6_idle_count", q_count, 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? HALT : 12'($urandom_range(0, 12'hFFE));
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 8'($urandom);
            run            = ($urandom_range(0, 9) < 8);
            out_ready      = ($urandom_range(0, 9) < 7);
            cyc();
        end

        rst = 1'b0; redirect_valid = 1'b0; run = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
